instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the CPU datapath: owns the program counter, drives the instruction ROM and
//  captures each 16-bit word into the instruction register. Presents IR with its decoded fields
//  (opcode/dest/src) to the control unit through a valid/ready handshake.
//  Accepts branch redirects from the control unit and stops fetching on a HALT opcode.
// PARAMETERS
//  ADDR_W       8      PC / ROM address width; PC wraps modulo 2**ADDR_W
//  INSTR_W      16     instruction width; fields opcode[15:12], dest[11:6], src[5:0]
//  HALT_OPCODE  4'hF   opcode that stops fetching once the instruction is issued
// PORTS
//  clk             in   1        system clock, rising edge
//  reset           in   1        asynchronous, active-high
//  rom_address     out  ADDR_W   ROM read address (= fetch PC)
//  rom_read_enable out  1        ROM read strobe; ROM returns rom_data one cycle later
//  rom_data        in   INSTR_W  ROM read data, valid the cycle after rom_read_enable
//  ir              out  INSTR_W  instruction register
//  opcode          out  4        ir[15:12]
//  dest            out  6        ir[11:6]
//  src             out  6        ir[5:0]
//  ir_pc           out  ADDR_W   address the instruction in ir was fetched from
//  instr_valid     out  1        ir holds an instruction awaiting acceptance
//  instr_ready     in   1        control unit accepts ir this cycle
//  branch_taken    in   1        redirect; sampled only on an accept cycle
//  branch_target   in   ADDR_W   redirect address
//  halted          out  1        HALT issued; fetch stopped
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, fetch_pc=0, ir=0, ir_pc=0; all outputs 0.
//  FSM states (3-bit, registered): IDLE=0, FETCH=1, LOAD=2, ISSUE=3, HALT=4.
//  - IDLE : one cycle after reset release -> FETCH. No ROM access.
//  - FETCH: rom_read_enable=1, rom_address=fetch_pc -> LOAD.
//  - LOAD : ir<=rom_data, ir_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (8'hFF wraps to 8'h00) -> ISSUE.
//  - ISSUE: instr_valid=1; ir, ir_pc and the fields are held stable while instr_ready=0.
//           On instr_ready=1 (accept):
//             branch_taken=1 -> fetch_pc<=branch_target (overrides the +1 increment).
//             opcode==HALT_OPCODE -> HALT, else -> FETCH.
//             Branch and HALT in the same accept: HALT wins; fetch_pc still updates.
//  - HALT : halted=1, instr_valid=0, rom_read_enable=0; held until reset.
//  Outputs are decodes of state/registers: rom_read_enable only in FETCH, instr_valid only in
//  ISSUE. opcode/dest/src are combinational slices of ir. rom_address is 0 outside FETCH.
//  branch_taken outside an accept cycle is ignored (no latch, no effect).
//  Latency: FETCH->ISSUE is 2 cycles. Peak throughput is 1 instruction per 3 cycles, with
//  instr_ready tied high.
//  Reset mid-operation: any state returns to IDLE immediately and the pending ir is discarded.
//  Illegal state encodings (5-7) -> IDLE on the next clock.
// TESTING
//  1. ROM[0..2]=16'h1041,16'h2082,16'h30C3, ready=1 -> ir sequence 1041/2082/30C3; ir_pc 0,1,2;
//     instr_valid pulses every 3rd cycle.
//  2. ready=0 for 5 cycles in ISSUE -> ir and instr_valid held; no rom_read_enable; fetch_pc unchanged.
//  3. Accept at ir_pc=3 with branch_taken=1, target=8'h40 -> next rom_address=8'h40, ir_pc=8'h40.
//  4. ROM[8'hFF]=16'h1000 with ready=1 -> next fetch at rom_address=8'h00 (wrap).
//  5. ROM[2]=16'hF000 -> issued once, then halted=1; rom_read_enable stays 0 for 20 cycles.
//  6. Assert reset while in ISSUE (ir=16'h2082) -> same-cycle instr_valid=0, ir=0;
//     after release: IDLE, then FETCH from address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and hands each
// captured instruction to the control unit over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int          ADDR_W      = 8,
   parameter int          INSTR_W     = 16,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_address,
   output logic               rom_read_enable,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [5:0]         dest,
   output logic [5:0]         src,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               halted
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      ISSUE = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] fetch_pc;
   logic              accept;

   assign accept = (state == ISSUE) && instr_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Unused encodings fall into the default arm and recover through IDLE.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:  state_next = FETCH;
         FETCH: state_next = LOAD;
         LOAD:  state_next = ISSUE;
         ISSUE: begin
            if (!accept) begin
               state_next = ISSUE;
            end else if (ir[15:12] == HALT_OPCODE) begin
               state_next = HALT;
            end else begin
               state_next = FETCH;
            end
         end
         HALT:  state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   // A taken branch replaces the increment applied in LOAD, even when halting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= '0;
         ir       <= '0;
         ir_pc    <= '0;
      end else if (state == LOAD) begin
         ir       <= rom_data;
         ir_pc    <= fetch_pc;
         fetch_pc <= fetch_pc + ADDR_W'(1);
      end else if (accept && branch_taken) begin
         fetch_pc <= branch_target;
      end
   end

   assign rom_read_enable = (state == FETCH);
   assign rom_address     = rom_read_enable ? fetch_pc : '0;
   assign instr_valid     = (state == ISSUE);
   assign halted          = (state == HALT);
   assign opcode          = ir[15:12];
   assign dest            = ir[11:6];
   assign src             = ir[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-order model pushes expected
// instructions on each accept; a monitor checks every cycle of the handshake.
module tb_instr_fetch_unit;

   typedef struct {
      logic [15:0] word;
      logic [7:0]  pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rom_address;
   logic        rom_read_enable;
   logic [15:0] rom_data = 16'h0000;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic [5:0]  dest;
   logic [5:0]  src;
   logic [7:0]  ir_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic        halted;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .rom_address    (rom_address),
      .rom_read_enable(rom_read_enable),
      .rom_data       (rom_data),
      .ir             (ir),
      .opcode         (opcode),
      .dest           (dest),
      .src            (src),
      .ir_pc          (ir_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] rom [256];
   exp_t        q [$];
   logic [7:0]  model_pc = 8'h00;
   bit          model_halted = 1'b0;
   bit          mon_en = 1'b0;
   bit          mon_fresh = 1'b0;
   int          since = 0;
   bit          acc_prev = 1'b0;
   bit          halt_flag = 1'b0;
   exp_t        cur;
   logic        last_ren = 1'b0;
   logic [7:0]  last_addr = 8'h00;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      return w;
   endfunction

   task automatic fill_rom();
      for (int i = 0; i < 256; i++) rom[i] = rand_word();
   endtask

   // Program-order model: the instruction following an accept is at target or pc+1.
   task automatic model_accept(input bit br, input logic [7:0] tgt);
      logic [7:0] nxt;
      if (rom[model_pc][15:12] == 4'hF) begin
         model_halted = 1'b1;
      end else begin
         nxt = br ? tgt : model_pc + 8'd1;
         model_pc = nxt;
         q.push_back(exp_t'{rom[nxt], nxt});
      end
   endtask

   task automatic reset_dut();
      mon_en = 1'b0;
      reset = 1'b1;
      instr_ready = 1'b0;
      branch_taken = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      model_pc = 8'h00;
      model_halted = 1'b0;
      q.push_back(exp_t'{rom[0], 8'h00});
      @(negedge clk);
      reset = 1'b0;
      mon_fresh = 1'b1;
      mon_en = 1'b1;
   endtask

   // mode 0: ready high with fixed branches, 1: random, 2: stall, 3: stall on pc 1
   task automatic apply_stimulus(input int mode, input int n);
      bit         rdy;
      bit         br;
      logic [7:0] tgt;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rdy = 1'b1;
         br  = 1'b0;
         tgt = 8'($urandom);
         case (mode)
            0: begin
               if (instr_valid && model_pc == 8'h03) begin
                  br = 1'b1; tgt = 8'h40;
               end else if (instr_valid && model_pc == 8'h44) begin
                  br = 1'b1; tgt = 8'hFE;
               end else if (!instr_valid) begin
                  br = 1'($urandom_range(0, 1));
               end
            end
            1: begin
               rdy = 1'($urandom_range(0, 1));
               br  = ($urandom_range(0, 3) == 0);
            end
            2: begin
               rdy = 1'b0;
               br  = 1'($urandom_range(0, 1));
            end
            default: rdy = (model_pc != 8'h01);
         endcase
         instr_ready = rdy;
         branch_taken = br;
         branch_target = tgt;
         if (instr_valid && rdy && !model_halted) model_accept(br, tgt);
      end
   endtask

   // ROM responds in the cycle after a read strobe; junk is driven otherwise.
   initial begin
      forever begin
         @(negedge clk);
         if (last_ren) rom_data = rom[last_addr];
         else rom_data = 16'($urandom);
         last_ren = rom_read_enable;
         last_addr = rom_address;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!mon_en) continue;
         if (mon_fresh) begin
            mon_fresh = 1'b0;
            since = 0;
            acc_prev = 1'b0;
            halt_flag = 1'b0;
            check_output("idle_valid", instr_valid, 0);
            check_output("idle_ren", rom_read_enable, 0);
            check_output("idle_ir", ir, 0);
            continue;
         end
         since = acc_prev ? 1 : since + 1;
         acc_prev = 1'b0;
         if (halt_flag) begin
            check_output("halted", halted, 1);
            check_output("halt_ren", rom_read_enable, 0);
            check_output("halt_valid", instr_valid, 0);
         end else begin
            check_output("not_halted", halted, 0);
            check_output("ren", rom_read_enable, (since == 1));
            if (since == 1) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("[TB] FAIL rom_address: no expected fetch queued at %0t", $time);
               end else begin
                  check_output("rom_address", rom_address, q[0].pc);
               end
            end else begin
               check_output("rom_address_idle", rom_address, 0);
            end
            check_output("instr_valid", instr_valid, (since >= 3));
            if (since == 3) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("[TB] FAIL issue: got ir %0h with no expected entry", ir);
               end else begin
                  cur = q.pop_front();
                  check_output("ir", ir, cur.word);
                  check_output("ir_pc", ir_pc, cur.pc);
                  check_output("opcode", opcode, cur.word[15:12]);
                  check_output("dest", dest, cur.word[11:6]);
                  check_output("src", src, cur.word[5:0]);
               end
            end else if (since > 3) begin
               check_output("ir_hold", ir, cur.word);
               check_output("ir_pc_hold", ir_pc, cur.pc);
            end
            if (since >= 3 && instr_ready) begin
               acc_prev = 1'b1;
               if (cur.word[15:12] == 4'hF) halt_flag = 1'b1;
            end
         end
      end
   end

   initial begin
      bit found;
      #2;
      check_output("rst_ir", ir, 0);
      check_output("rst_ir_pc", ir_pc, 0);
      check_output("rst_valid", instr_valid, 0);
      check_output("rst_ren", rom_read_enable, 0);
      check_output("rst_addr", rom_address, 0);
      check_output("rst_halted", halted, 0);

      $display("[TB] directed sequence, stall, branch and wrap");
      fill_rom();
      rom[0] = 16'h1041; rom[1] = 16'h2082; rom[2] = 16'h30C3; rom[8'hFF] = 16'h1000;
      reset_dut();
      apply_stimulus(0, 12);
      apply_stimulus(2, 8);
      apply_stimulus(0, 45);

      $display("[TB] random handshake and branches");
      fill_rom();
      reset_dut();
      apply_stimulus(1, 600);

      $display("[TB] halt");
      fill_rom();
      rom[2] = 16'hF000;
      reset_dut();
      apply_stimulus(0, 35);

      $display("[TB] reset during issue");
      fill_rom();
      rom[0] = 16'h1041; rom[1] = 16'h2082; rom[2] = 16'h30C3;
      reset_dut();
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         apply_stimulus(3, 1);
         if (model_pc == 8'h01 && instr_valid && !instr_ready) found = 1'b1;
      end
      if (!found) begin
         total++; bad++;
         $display("[TB] FAIL reach_issue: second instruction never presented");
      end
      check_output("pre_reset_ir", ir, 16'h2082);
      mon_en = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_output("async_valid", instr_valid, 0);
      check_output("async_ir", ir, 0);
      check_output("async_ir_pc", ir_pc, 0);
      reset_dut();
      apply_stimulus(0, 12);

      mon_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
